// File: rtl/pc_sequencer.sv
// Program-counter sequencer: launches one of three stored programs, then steps,
// branches, stalls or halts the PC each cycle under a RUN-cycle watchdog.
module pc_sequencer #(
  parameter int unsigned     PW         = 16,
  parameter int unsigned     CW         = 16,
  parameter logic [PW-1:0]   START0     = 0,
  parameter logic [PW-1:0]   START1     = 64,
  parameter logic [PW-1:0]   START2     = 128,
  parameter logic [PW-1:0]   PC_MAX     = 255,
  parameter int unsigned     MAX_CYCLES = 4000
) (
  input  logic          CLK,
  input  logic          init_n,
  input  logic          start,
  input  logic [1:0]    prog_sel,
  input  logic          instr_halt,
  input  logic          br_en,
  input  logic          br_cond,
  input  logic          br_rel,
  input  logic [PW-1:0] br_target,
  input  logic          mem_wait,
  output logic [PW-1:0] PC,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic          halt,
  output logic          fault,
  output logic [CW-1:0] cycles,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);

  state_t        r_state;
  logic          w_launch;
  logic [PW-1:0] w_start_pc;
  logic          w_taken;
  logic [PW-1:0] w_target;
  logic [CW-1:0] w_cyc_next;
  logic          w_fault;

  assign w_launch = start && (prog_sel != 2'd3);
  assign w_taken  = br_en && br_cond;
  // Relative targets wrap modulo 2^PW before the range check.
  assign w_target = br_rel ? (PC + br_target) : br_target;
  assign w_cyc_next = (&cycles) ? cycles : cycles + 1'b1;

  always_comb begin
    w_start_pc = START0;
    case (prog_sel)
      2'd1:    w_start_pc = START1;
      2'd2:    w_start_pc = START2;
      default: w_start_pc = START0;
    endcase
  end

  // Watchdog trips regardless of stalls; otherwise only a PC move can fault.
  assign w_fault = (cycles >= WD_LAST) ||
                   (!mem_wait && (w_taken ? (w_target > PC_MAX) : (PC == PC_MAX)));

  assign fetch_valid = (r_state == S_RUN) && !mem_wait;
  assign dbg_state   = r_state;

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      r_state <= S_IDLE;
      PC      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      halt    <= 1'b0;
      fault   <= 1'b0;
      cycles  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_RUN: begin
          cycles <= w_cyc_next;
          if (instr_halt) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            halt    <= 1'b1;
          end else if (w_fault) begin
            r_state <= S_FAULT;
            busy    <= 1'b0;
            halt    <= 1'b1;
            fault   <= 1'b1;
          end else if (!mem_wait) begin
            PC <= w_taken ? w_target : PC + 1'b1;
          end
        end
        default: begin
          if (w_launch) begin
            r_state <= S_RUN;
            PC      <= w_start_pc;
            cycles  <= '0;
            busy    <= 1'b1;
            halt    <= 1'b0;
            fault   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random stimulus, two instances
// (default watchdog and an 8-cycle watchdog) compared every cycle to a model.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        init_n;
  logic        start;
  logic [1:0]  prog_sel;
  logic        instr_halt;
  logic        br_en;
  logic        br_cond;
  logic        br_rel;
  logic [15:0] br_target;
  logic        mem_wait;

  logic [15:0] pc_a, cyc_a, pc_b, cyc_b;
  logic        fv_a, busy_a, done_a, halt_a, fault_a;
  logic        fv_b, busy_b, done_b, halt_b, fault_b;
  logic [1:0]  st_a, st_b;

  pc_sequencer u_dut (
    .CLK(CLK), .init_n(init_n), .start(start), .prog_sel(prog_sel),
    .instr_halt(instr_halt), .br_en(br_en), .br_cond(br_cond), .br_rel(br_rel),
    .br_target(br_target), .mem_wait(mem_wait),
    .PC(pc_a), .fetch_valid(fv_a), .busy(busy_a), .done(done_a), .halt(halt_a),
    .fault(fault_a), .cycles(cyc_a), .dbg_state(st_a)
  );

  pc_sequencer #(.MAX_CYCLES(8)) u_wdg (
    .CLK(CLK), .init_n(init_n), .start(start), .prog_sel(prog_sel),
    .instr_halt(instr_halt), .br_en(br_en), .br_cond(br_cond), .br_rel(br_rel),
    .br_target(br_target), .mem_wait(mem_wait),
    .PC(pc_b), .fetch_valid(fv_b), .busy(busy_b), .done(done_b), .halt(halt_b),
    .fault(fault_b), .cycles(cyc_b), .dbg_state(st_b)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // behavioural model: mode 0 idle, 1 run, 2 done, 3 fault
  typedef struct {
    int mode;
    int pc;
    int cyc;
    bit dn;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.pc = 0; r.cyc = 0; r.dn = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t c, int maxc);
    mdl_t n;
    int   tgt;
    n    = c;
    n.dn = 1'b0;
    if (c.mode != 1) begin
      if (start && prog_sel != 2'd3) begin
        n.mode = 1;
        n.pc   = 64 * int'(prog_sel);
        n.cyc  = 0;
      end
      return n;
    end
    n.cyc = (c.cyc == 65535) ? c.cyc : c.cyc + 1;
    if (instr_halt) begin
      n.mode = 2;
      n.dn   = 1'b1;
    end else if (c.cyc >= maxc - 1) begin
      n.mode = 3;
    end else if (mem_wait) begin
      n.pc = c.pc;
    end else if (br_en && br_cond) begin
      tgt = br_rel ? (c.pc + int'(br_target)) % 65536 : int'(br_target);
      if (tgt > 255) n.mode = 3;
      else           n.pc = tgt;
    end else if (c.pc == 255) begin
      n.mode = 3;
    end else begin
      n.pc = c.pc + 1;
    end
    return n;
  endfunction

  mdl_t m_a = '{mode: 0, pc: 0, cyc: 0, dn: 1'b0};
  mdl_t m_b = '{mode: 0, pc: 0, cyc: 0, dn: 1'b0};

  always @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      m_a <= mdl_reset();
      m_b <= mdl_reset();
    end else begin
      m_a <= mdl_next(m_a, 4000);
      m_b <= mdl_next(m_b, 8);
    end
  end

  // scoreboard: hand-computed literal expectations, checked at the next negedge
  typedef struct {
    string name;
    int    sig;   // 0 PC, 1 fetch_valid, 2 busy, 3 done, 4 halt, 5 fault, 6 cycles
    int    exp;
    bit    wdg;
  } lit_t;
  lit_t lit_q[$];

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d at %0t", name, act, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input mdl_t m, input logic [15:0] pc,
                          input logic fv, input logic bz, input logic dn,
                          input logic hl, input logic ft, input logic [15:0] cyc);
    chk({tag, ".PC"},          {16'b0, pc},  m.pc);
    chk({tag, ".fetch_valid"}, {31'b0, fv},  int'(m.mode == 1 && !mem_wait));
    chk({tag, ".busy"},        {31'b0, bz},  int'(m.mode == 1));
    chk({tag, ".done"},        {31'b0, dn},  int'(m.dn));
    chk({tag, ".halt"},        {31'b0, hl},  int'(m.mode >= 2));
    chk({tag, ".fault"},       {31'b0, ft},  int'(m.mode == 3));
    chk({tag, ".cycles"},      {16'b0, cyc}, m.cyc);
  endtask

  function automatic logic [31:0] act_of(input int sig, input bit wdg);
    case (sig)
      0:       return wdg ? {16'b0, pc_b}    : {16'b0, pc_a};
      1:       return wdg ? {31'b0, fv_b}    : {31'b0, fv_a};
      2:       return wdg ? {31'b0, busy_b}  : {31'b0, busy_a};
      3:       return wdg ? {31'b0, done_b}  : {31'b0, done_a};
      4:       return wdg ? {31'b0, halt_b}  : {31'b0, halt_a};
      5:       return wdg ? {31'b0, fault_b} : {31'b0, fault_a};
      default: return wdg ? {16'b0, cyc_b}   : {16'b0, cyc_a};
    endcase
  endfunction

  // compare process
  always @(negedge CLK) begin
    lit_t l;
    if (chk_en) begin
      cmp_inst("dut", m_a, pc_a, fv_a, busy_a, done_a, halt_a, fault_a, cyc_a);
      cmp_inst("wdg", m_b, pc_b, fv_b, busy_b, done_b, halt_b, fault_b, cyc_b);
      while (lit_q.size() > 0) begin
        l = lit_q.pop_front();
        chk({"lit.", l.name}, act_of(l.sig, l.wdg), l.exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; prog_sel = 2'd0; instr_halt = 1'b0; br_en = 1'b0;
    br_cond = 1'b0; br_rel = 1'b0; br_target = 16'd0; mem_wait = 1'b0;
  endtask

  task automatic launch(input logic [1:0] p);
    start = 1'b1; prog_sel = p;
    tick();
    start = 1'b0;
  endtask

  task automatic lit(input string nm, input int sig, input int ex);
    lit_t l;
    l.name = nm; l.sig = sig; l.exp = ex; l.wdg = 1'b0;
    lit_q.push_back(l);
  endtask

  task automatic lit_w(input string nm, input int sig, input int ex);
    lit_t l;
    l.name = nm; l.sig = sig; l.exp = ex; l.wdg = 1'b1;
    lit_q.push_back(l);
  endtask

  task automatic branch(input logic rel, input logic [15:0] tgt);
    br_en = 1'b1; br_cond = 1'b1; br_rel = rel; br_target = tgt;
  endtask

  initial begin
    init_n = 1'b0;
    idle_in();
    repeat (2) @(posedge CLK);
    #1;
    chk_en = 1'b1;
    lit("rst_pc", 0, 0); lit("rst_fv", 1, 0); lit("rst_busy", 2, 0);
    lit("rst_done", 3, 0); lit("rst_halt", 4, 0); lit("rst_fault", 5, 0);
    lit("rst_cycles", 6, 0);
    tick();
    init_n = 1'b1;
    tick();

    // program 1 straight-line, including an untaken branch
    launch(2'd1);
    lit("p1_pc0", 0, 64); lit("p1_cyc0", 6, 0); lit("p1_fv", 1, 1); lit("p1_busy", 2, 1);
    tick(); lit("p1_pc1", 0, 65); lit("p1_cyc1", 6, 1);
    tick(); lit("p1_pc2", 0, 66); lit("p1_cyc2", 6, 2);
    br_en = 1'b1; br_cond = 1'b0; br_target = 16'd200;
    tick(); idle_in(); lit("p1_untaken_pc", 0, 67); lit("p1_cyc3", 6, 3);
    instr_halt = 1'b1;
    tick(); idle_in();
    lit("p1_done", 3, 1); lit("p1_halt", 4, 1); lit("p1_pc_hold", 0, 67); lit("p1_busy_off", 2, 0);
    tick(); lit("p1_done_off", 3, 0); lit("p1_halt_lvl", 4, 1);

    // program 0 with absolute branch 3 -> 10, halt at 12
    launch(2'd0); lit("p0_pc0", 0, 0); lit("p0_halt_clr", 4, 0);
    tick(); lit("p0_pc1", 0, 1);
    tick(); lit("p0_pc2", 0, 2);
    tick(); lit("p0_pc3", 0, 3);
    branch(1'b0, 16'd10);
    tick(); idle_in(); lit("p0_pc10", 0, 10);
    tick(); lit("p0_pc11", 0, 11);
    tick(); lit("p0_pc12", 0, 12);
    instr_halt = 1'b1;
    tick(); idle_in();
    lit("p0_pc_end", 0, 12); lit("p0_done", 3, 1); lit("p0_halt", 4, 1); lit("p0_cycles", 6, 7);
    tick(); lit("p0_done_once", 3, 0);

    // relative branch backwards: 130 + 0xFFFE -> 128
    launch(2'd2);
    tick(); tick(); lit("rel_pc130", 0, 130);
    branch(1'b1, 16'hFFFE);
    tick(); idle_in(); lit("rel_back_pc", 0, 128); lit("rel_back_cyc", 6, 3);
    instr_halt = 1'b1;
    tick(); idle_in();

    // relative branch out of range: 250 + 10 -> fault
    launch(2'd2);
    branch(1'b0, 16'd250);
    tick(); lit("oor_pc250", 0, 250);
    branch(1'b1, 16'd10);
    tick(); idle_in();
    lit("oor_fault", 5, 1); lit("oor_halt", 4, 1); lit("oor_pc", 0, 250);
    lit("oor_busy", 2, 0); lit("oor_done", 3, 0); lit("oor_cyc", 6, 2); lit("oor_fv", 1, 0);

    // three-cycle memory stall at PC 5
    launch(2'd0); lit("st_fault_clr", 5, 0); lit("st_halt_clr", 4, 0); lit("st_pc0", 0, 0);
    repeat (5) tick();
    lit("st_pc5", 0, 5); lit("st_cyc5", 6, 5);
    mem_wait = 1'b1;
    lit("st_fv0_a", 1, 0); lit("st_pc_a", 0, 5);
    for (int i = 0; i < 2; i++) begin
      tick(); lit("st_fv0_b", 1, 0); lit("st_pc_b", 0, 5);
    end
    tick(); mem_wait = 1'b0;
    lit("st_pc_after", 0, 5); lit("st_fv1", 1, 1); lit("st_cyc8", 6, 8);
    tick(); lit("st_pc6", 0, 6); lit("st_cyc9", 6, 9);

    // halt wins over stall and taken branch
    instr_halt = 1'b1; mem_wait = 1'b1; branch(1'b0, 16'd100);
    lit("pri_fv", 1, 0);
    tick(); idle_in();
    lit("pri_pc", 0, 6); lit("pri_done", 3, 1); lit("pri_fault", 5, 0); lit("pri_cyc", 6, 10);

    // branch-to-self loop against the 8-cycle watchdog
    launch(2'd0); lit_w("wd_pc0", 0, 0);
    branch(1'b0, 16'd0);
    repeat (7) tick();
    lit_w("wd_nofault", 5, 0); lit_w("wd_cyc7", 6, 7); lit_w("wd_busy", 2, 1);
    tick();
    lit_w("wd_fault", 5, 1); lit_w("wd_halt", 4, 1); lit_w("wd_cyc8", 6, 8); lit_w("wd_pc", 0, 0);
    lit("wd_dut_busy", 2, 1); lit("wd_dut_cyc", 6, 8);
    tick(); idle_in();

    // asynchronous reset mid-run
    init_n = 1'b0;
    lit("ar_pc", 0, 0); lit("ar_busy", 2, 0); lit("ar_cyc", 6, 0); lit("ar_fv", 1, 0);
    lit("ar_halt", 4, 0); lit("ar_done", 3, 0); lit("ar_fault", 5, 0);
    tick(); init_n = 1'b1;
    tick();

    // invalid program select ignored, then program 2
    start = 1'b1; prog_sel = 2'd3;
    tick(); start = 1'b0;
    lit("inv_busy", 2, 0); lit("inv_pc", 0, 0); lit("inv_halt", 4, 0);
    launch(2'd2); lit("p2_pc", 0, 128); lit("p2_busy", 2, 1);
    instr_halt = 1'b1;
    tick(); idle_in();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      init_n     = ($urandom_range(0, 599) != 0);
      start      = ($urandom_range(0, 7) == 0);
      prog_sel   = 2'($urandom_range(0, 3));
      instr_halt = ($urandom_range(0, 79) == 0);
      mem_wait   = ($urandom_range(0, 4) == 0);
      br_en      = ($urandom_range(0, 5) == 0);
      br_cond    = 1'($urandom_range(0, 1));
      br_rel     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       br_target = 16'($urandom_range(0, 300));
        1:       br_target = 16'(int'($urandom_range(0, 40)) - 20);
        2:       br_target = 16'($urandom);
        default: br_target = 16'($urandom_range(240, 255));
      endcase
      tick();
    end
    init_n = 1'b1;
    idle_in();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
